// File: rtl/edgegen.sv
// Edge/pulse generator: turns one request into a setup/pulse/final sequence on masked output bits.
// Optional macro EDGEGEN_GAP_EN adds GAP idle cycles (req_ready low) starting with the done cycle.
module edgegen #(
    parameter int DW  = 32,
    parameter int CW  = 8,
    parameter int GAP = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    cfg,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] mask,
    input  logic [CW-1:0] width,
    output logic [DW-1:0] out,
    output logic          busy,
    output logic          done
);

    localparam int GW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_GAP   = 2'd3
    } state_t;

`ifdef EDGEGEN_GAP_EN
    localparam bit GAP_ON = (GAP > 0);
`else
    localparam bit GAP_ON = 1'b0;
`endif

    localparam state_t        FIN_STATE = GAP_ON ? S_GAP : S_IDLE;
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);

    state_t        r_state;
    logic [DW-1:0] r_out;
    logic          r_done;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gcnt;
    logic [DW-1:0] r_mask;
    logic [CW-1:0] r_wid;
    logic          r_act;
    logic          w_accept;

    function automatic logic [DW-1:0] f_drive(input logic [DW-1:0] cur,
                                              input logic [DW-1:0] m,
                                              input logic          lvl);
        return (cur & ~m) | (m & {DW{lvl}});
    endfunction

    // Pulse length W is max(width,1); the counter holds W-1 so exactly W PULSE cycles run.
    function automatic logic [CW-1:0] f_load(input logic [CW-1:0] wid);
        return (wid == '0) ? '0 : (wid - CW'(1));
    endfunction

    assign req_ready = (r_state == S_IDLE);
    assign busy      = ~req_ready;
    assign done      = r_done;
    assign out       = r_out;
    assign w_accept  = req_valid & req_ready;

    // Request capture: only meaningful after an accept, so left without reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mask <= mask;
            r_wid  <= width;
            r_act  <= ~cfg[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_gcnt  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        case (cfg)
                            2'b00: begin
                                r_done  <= 1'b1;
                                r_state <= FIN_STATE;
                                r_gcnt  <= GAP_LOAD;
                            end
                            2'b11: begin
                                r_out   <= r_out ^ mask;
                                r_done  <= 1'b1;
                                r_state <= FIN_STATE;
                                r_gcnt  <= GAP_LOAD;
                            end
                            default: begin
                                // Pre-level is the inverse of the active level: 0 for rising, 1 for falling.
                                r_out   <= f_drive(r_out, mask, cfg[1]);
                                r_state <= S_SETUP;
                            end
                        endcase
                    end
                end
                S_SETUP: begin
                    r_out   <= f_drive(r_out, r_mask, r_act);
                    r_cnt   <= f_load(r_wid);
                    r_state <= S_PULSE;
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_out   <= f_drive(r_out, r_mask, ~r_act);
                        r_done  <= 1'b1;
                        r_state <= FIN_STATE;
                        r_gcnt  <= GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_gcnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt - GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edgegen.sv
// Self-checking bench for edgegen: vector table, directed corner sequences, and randomized
// traffic compared against a per-cycle timeline model.
module tb_edgegen;

    localparam int DW     = 32;
    localparam int CW     = 8;
    localparam int TB_GAP = 2;
`ifdef EDGEGEN_GAP_EN
    localparam bit GAPEN = (TB_GAP > 0);
`else
    localparam bit GAPEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    cfg;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] mask;
    logic [CW-1:0] width;
    logic [DW-1:0] out;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    edgegen #(.DW(DW), .CW(CW), .GAP(TB_GAP)) dut (
        .clk(clk), .reset(reset), .cfg(cfg), .req_valid(req_valid),
        .req_ready(req_ready), .mask(mask), .width(width), .out(out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    cfg;
        logic [DW-1:0] mask;
        logic [CW-1:0] width;
        logic [DW-1:0] exp_out;
        int            exp_lat;
    } vec_t;

    typedef struct {
        logic [DW-1:0] o;
        logic          d;
        logic          r;
    } exp_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lvl(input logic [DW-1:0] b, input logic [DW-1:0] m, input logic l);
        return l ? (b | m) : (b & ~m);
    endfunction

    task automatic drv(input logic v, input logic [1:0] c, input logic [DW-1:0] m, input logic [CW-1:0] w);
        req_valid = v;
        cfg       = c;
        mask      = m;
        width     = w;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'd1);
    endtask

    // Issues one op and counts edges from the accepting edge until done is seen.
    task automatic run_op(input logic [1:0] c, input logic [DW-1:0] m, input logic [CW-1:0] w,
                          output int lat, output logic [DW-1:0] o);
        wait_ready();
        drv(1'b1, c, m, w);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        o = out;
    endtask

    initial begin
        int            lat;
        int            seen;
        logic [DW-1:0] o;
        logic [DW-1:0] x;
        logic          e_out0 [5];
        logic          e_done [5];
        exp_t          q [$];
        exp_t          cur;

        tbl[0] = '{2'b01, 32'h0000_0001, 8'd3,   32'h0000_0000, 5};
        tbl[1] = '{2'b10, 32'h0000_00F0, 8'd0,   32'h0000_00F0, 3};
        tbl[2] = '{2'b11, 32'h0000_00A5, 8'd0,   32'h0000_0055, 1};
        tbl[3] = '{2'b11, 32'h0000_00A5, 8'd9,   32'h0000_00F0, 1};
        tbl[4] = '{2'b00, 32'h0000_00FF, 8'd7,   32'h0000_00F0, 1};
        tbl[5] = '{2'b01, 32'h0000_FF00, 8'd2,   32'h0000_00F0, 4};
        tbl[6] = '{2'b10, 32'h0000_000F, 8'd1,   32'h0000_00FF, 3};
        tbl[7] = '{2'b01, 32'h0000_0000, 8'd5,   32'h0000_00FF, 7};
        tbl[8] = '{2'b10, 32'hFFFF_0000, 8'd255, 32'hFFFF_00FF, 257};
        tbl[9] = '{2'b01, 32'h8000_0001, 8'd4,   32'h7FFF_00FE, 6};
        e_out0 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        e_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1;
        drv(1'b0, 2'b00, '0, '0);
        repeat (2) @(negedge clk);
        chk("reset_out", 64'(out), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);

        // Rising pulse, width 3, traced cycle by cycle.
        drv(1'b1, 2'b01, 32'h1, 8'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("rise_out0_c%0d", i + 1), 64'(out[0]), 64'(e_out0[i]));
            chk($sformatf("rise_done_c%0d", i + 1), 64'(done), 64'(e_done[i]));
        end

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].cfg, tbl[i].mask, tbl[i].width, lat, o);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_out", i), 64'(o), 64'(tbl[i].exp_out));
        end

`ifndef EDGEGEN_GAP_EN
        // Back-to-back toggles: second request lands in the first op's done cycle.
        wait_ready();
        x = out;
        drv(1'b1, 2'b11, 32'hA5, 8'd0);
        @(negedge clk);
        chk("b2b_out1", 64'(out), 64'(x ^ 32'hA5));
        chk("b2b_done1", 64'(done), 64'd1);
        chk("b2b_ready1", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_out2", 64'(out), 64'(x));
        chk("b2b_done2", 64'(done), 64'd1);
        @(negedge clk);
        chk("b2b_done3", 64'(done), 64'd0);
`endif

        // Inputs changed while the op runs must not disturb it.
        wait_ready();
        x = out;
        drv(1'b1, 2'b01, 32'h3, 8'd4);
        @(negedge clk);
        drv(1'b0, 2'b11, 32'hFFFF_FFFF, 8'd1);
        lat = 1;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("midop_lat", 64'(lat), 64'd6);
        chk("midop_out", 64'(out), 64'(x & ~32'h3));
        x = out;
        run_op(2'b00, 32'hFF, 8'd9, lat, o);
        chk("off_lat", 64'(lat), 64'd1);
        chk("off_out", 64'(o), 64'(x));

`ifdef EDGEGEN_GAP_EN
        wait_ready();
        x = out;
        drv(1'b1, 2'b11, 32'h0F, 8'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("gap_done", 64'(done), 64'd1);
        chk("gap_out", 64'(out), 64'(x ^ 32'h0F));
        chk("gap_ready1", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("gap_ready2", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("gap_ready3", 64'(req_ready), 64'd1);
`endif

        // Asynchronous reset in the middle of a width-10 rising pulse.
        wait_ready();
        x = out;
        drv(1'b1, 2'b01, 32'hF, 8'd10);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_out", 64'(out), 64'(x | 32'hF));
        chk("rst_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_out", 64'(out), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || out != 0) seen++;
        end
        chk("rst_no_done", 64'(seen), 64'd0);

        // Randomized traffic against a timeline model of expected out/done/ready.
        cur = '{'0, 1'b0, 1'b1};
        for (int n = 0; n < 3000; n++) begin
            logic          v;
            logic          acc;
            logic [1:0]    c;
            logic [DW-1:0] m;
            logic [CW-1:0] w;
            logic [DW-1:0] base;
            logic [DW-1:0] fin;
            logic          pre;
            int            wd;
            chk("rnd_out", 64'(out), 64'(cur.o));
            chk("rnd_done", 64'(done), 64'(cur.d));
            chk("rnd_ready", 64'(req_ready), 64'(cur.r));
            chk("rnd_busy", 64'(busy), 64'(!cur.r));
            v = 1'($urandom_range(0, 1));
            c = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       m = '0;
                1:       m = '1;
                default: m = $urandom;
            endcase
            w = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 40)) : CW'($urandom_range(0, 4));
            drv(v, c, m, w);
            acc = v && cur.r;
            @(posedge clk);
            if (acc) begin
                base = cur.o;
                if (c == 2'b00 || c == 2'b11) begin
                    fin = (c == 2'b11) ? (base ^ m) : base;
                    q.push_back('{fin, 1'b1, !GAPEN});
                end else begin
                    pre = (c == 2'b10);
                    wd  = (w == 0) ? 1 : int'(w);
                    q.push_back('{lvl(base, m, pre), 1'b0, 1'b0});
                    for (int i = 0; i < wd; i++) q.push_back('{lvl(base, m, !pre), 1'b0, 1'b0});
                    fin = lvl(base, m, pre);
                    q.push_back('{fin, 1'b1, !GAPEN});
                end
                if (GAPEN) begin
                    for (int i = 1; i < TB_GAP; i++) q.push_back('{fin, 1'b0, 1'b0});
                end
            end
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur.d = 1'b0;
                cur.r = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
